// File: rtl/i2s_cfg_pkg.sv
// -----------------------------------------------------------------------------
// i2s_cfg_pkg
// Shared configuration for the I2S clock scheduler:
//   - sched_state_e   : scheduler FSM state encoding
//   - FRAME_CNT_W     : width of the completed-frame counter
//   - DEFAULT_SLOT_BITS : default number of SCK periods per WS half-frame
//   - bit_cnt_width() : width needed to hold 0 .. 2*slot_bits-1
// -----------------------------------------------------------------------------
package i2s_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARM  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  localparam int FRAME_CNT_W       = 16;
  localparam int DEFAULT_SLOT_BITS = 32;

  function automatic int bit_cnt_width(input int slot_bits);
    return (slot_bits > 1) ? $clog2(2 * slot_bits) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// -----------------------------------------------------------------------------
// i2s_clk_div
// SCK generator. A counter runs from 0 to div_half_i; on the terminal count
// sck toggles and the counter returns to 0, so one SCK period lasts
// 2*(div_half_i+1) clk cycles. While en_i is low the counter and sck are held
// at 0, so the first rising edge always comes div_half_i+1 cycles after enable.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   en_i       in   run the divider (low = hold everything at 0)
//   div_half_i in   SCK half-period in clk cycles minus 1
//   sck_o      out  registered bit clock
//   rise_o     out  high in the cycle whose closing edge takes sck 0->1
//   fall_o     out  high in the cycle whose closing edge takes sck 1->0
// -----------------------------------------------------------------------------
module i2s_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_half_i,
  output logic             sck_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             tc;

  assign tc = en_i && (cnt_q == div_half_i);

  // Strobes announce the edge that the next clock will register, so the
  // parent can register its own strobes alongside the sck transition.
  assign rise_o = tc && !sck_q;
  assign fall_o = tc && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tc) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/i2s_clk_sched.sv
// -----------------------------------------------------------------------------
// i2s_clk_sched
// I2S master clock scheduler for microphone capture. Generates SCK and WS,
// discards an optional number of warm-up frames, then flags every SCK rise
// as a sample point and counts completed frames. A stop request lets the
// current frame finish before returning to idle.
//
// Build option:
//   I2S_SCHED_WARMUP_EN  defined   -> IDLE -> WARM (WARMUP_FRAMES frames) -> RUN
//                        undefined -> IDLE -> RUN directly, no warm-up logic
//
// Ports:
//   sys_clk     in   clock for all logic
//   sys_rst_n   in   asynchronous active-low reset
//   start       in   single-cycle request to begin clocking (ignored when busy)
//   stop        in   single-cycle request to stop at the next frame end
//   div_half    in   SCK half-period minus 1, latched on start
//   busy        out  scheduler is not idle
//   sck         out  I2S bit clock
//   ws          out  I2S word select (0 = left, 1 = right)
//   sample_en   out  strobe coinciding with each SCK rise in RUN
//   frame_done  out  strobe at each frame end in RUN or DRAIN
//   frame_cnt   out  frames completed since the last start
// -----------------------------------------------------------------------------
module i2s_clk_sched
  import i2s_cfg_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int SLOT_BITS     = DEFAULT_SLOT_BITS,
  parameter int WARMUP_FRAMES = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [DIV_W-1:0]       div_half,
  output logic                   busy,
  output logic                   sck,
  output logic                   ws,
  output logic                   sample_en,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int               BIT_W     = bit_cnt_width(SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_HALF  = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);

  sched_state_e           state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   ws_q, ws_d;
  logic                   busy_q, busy_d;
  logic                   sample_en_q, sample_en_d;
  logic                   frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic clk_en;
  logic sck_int;
  logic sck_rise;
  logic sck_fall;
  logic frame_end;
  logic start_ok;
  logic leaving_idle;

  assign clk_en       = (state_q != ST_IDLE);
  assign frame_end    = sck_fall && (bit_cnt_q == BIT_LAST);
  // A simultaneous stop cancels the start.
  assign start_ok     = start && !stop;
  assign leaving_idle = (state_q == ST_IDLE) && (state_d != ST_IDLE);

  i2s_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .en_i       (clk_en),
    .div_half_i (div_q),
    .sck_o      (sck_int),
    .rise_o     (sck_rise),
    .fall_o     (sck_fall)
  );

`ifdef I2S_SCHED_WARMUP_EN
  localparam int WARM_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              warm_last;

  // warm_cnt_q holds the number of frame ends already seen in WARM.
  assign warm_last = (warm_cnt_q == WARM_W'(WARMUP_FRAMES - 1));

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (state_q != ST_WARM) begin
      warm_cnt_d = '0;
    end else if (frame_end) begin
      warm_cnt_d = warm_cnt_q + WARM_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      warm_cnt_q <= '0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      ws_q         <= 1'b0;
      busy_q       <= 1'b0;
      sample_en_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      ws_q         <= ws_d;
      busy_q       <= busy_d;
      sample_en_q  <= sample_en_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
`ifdef I2S_SCHED_WARMUP_EN
          state_d = (WARMUP_FRAMES > 0) ? ST_WARM : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef I2S_SCHED_WARMUP_EN
      ST_WARM: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (frame_end && warm_last) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. Strobes are qualified by the state in
  // which the edge is decided, so the pulse lands with the sck transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d        = div_q;
    bit_cnt_d    = bit_cnt_q;
    ws_d         = ws_q;
    busy_d       = (state_d != ST_IDLE);
    sample_en_d  = (state_q == ST_RUN) && sck_rise;
    frame_done_d = frame_end && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    frame_cnt_d  = frame_cnt_q;

    if (leaving_idle) begin
      div_d = div_half;
    end

    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
      ws_d      = 1'b0;
    end else if (sck_fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      // WS flips at the slot boundary and at the frame wrap.
      if ((bit_cnt_q == BIT_HALF) || (bit_cnt_q == BIT_LAST)) begin
        ws_d = !ws_q;
      end
    end

    if (leaving_idle) begin
      frame_cnt_d = '0;
    end else if (frame_done_d) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign busy       = busy_q;
  assign sck        = sck_int;
  assign ws         = ws_q;
  assign sample_en  = sample_en_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_i2s_clk_sched.sv
// -----------------------------------------------------------------------------
// tb_i2s_clk_sched
// Self-checking bench for i2s_clk_sched. The expected outputs for every cycle
// after a start come from an arithmetic model of the I2S timeline: edge n
// after the start edge has sck = floor(n/P) mod 2 (P = div_half+1), bit index
// floor(n/2P) mod 64, frame ends every 128*P edges, and so on.
// Works with or without I2S_SCHED_WARMUP_EN defined.
// -----------------------------------------------------------------------------
module tb_i2s_clk_sched;

`ifdef I2S_SCHED_WARMUP_EN
  localparam int W_EFF = 4;
`else
  localparam int W_EFF = 0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic        stop;
  logic [7:0]  div_half;
  logic        busy;
  logic        sck;
  logic        ws;
  logic        sample_en;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int checks;
  int errors;

  i2s_clk_sched #(
    .DIV_W         (8),
    .SLOT_BITS     (32),
    .WARMUP_FRAMES (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .div_half   (div_half),
    .busy       (busy),
    .sck        (sck),
    .ws         (ws),
    .sample_en  (sample_en),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Expected {busy, sck, ws, sample_en, frame_done, frame_cnt} after edge n,
  // where edge 0 samples start. p = div_half+1, w = warm-up frames,
  // s = edge that samples stop (-1 = never).
  function automatic logic [20:0] model(input int n, input int p, input int w, input int s);
    int   fl, e, lim, fc, m;
    logic b, c, wv, se, fd;
    fl = 128 * p;
    e  = (s < 0) ? 32'h7fff_ffff : (s / fl + 1) * fl;
    lim = (n < e) ? n : e;
    fc = 0;
    for (int k = 1; k * fl <= lim; k++) begin
      if ((k > w) || ((s >= 0) && (k * fl > s))) fc++;
    end
    if (n >= e) begin
      b = 1'b0; c = 1'b0; wv = 1'b0; se = 1'b0;
      fd = (n == e);
    end else begin
      b  = 1'b1;
      c  = ((n / p) % 2) == 1;
      m  = n / (2 * p);
      wv = (m % 64) >= 32;
      se = ((n % (2 * p)) == p) && (n > fl * w) && ((s < 0) || (n <= s));
      fd = (n > 0) && ((n % fl) == 0) && ((n > fl * w) || ((s >= 0) && (n > s)));
    end
    return {b, c, wv, se, fd, 16'(fc)};
  endfunction

  task automatic drive_start(input logic [7:0] d);
    div_half = d;
    start    = 1'b1;
    @(posedge sys_clk);
    #1;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    div_half  = 8'd0;
    repeat (3) @(posedge sys_clk);
    #1;
    got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", got, 21'd0);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      div_half = 8'($urandom);
      stop     = 1'($urandom);
      @(posedge sys_clk);
      #1;
      got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
      checks++;
      if (got !== 21'd0) begin
        errors++;
        $display("FAIL idle_after_reset i=%0d got=%h exp=%h", i, got, 21'd0);
      end
    end
    stop = 1'b0;
    $display("txn reset: outputs idle through reset and 16 cycles after release");
  endtask

  task automatic test_div0();
    int p, s, e, rise_a, rise_b, ws_a, ws_b, first_se;
    logic [15:0] fc128;
    logic prev_sck, prev_ws;
    logic [20:0] got, exp;
    p = 1;
    s = 128 * (W_EFF + 1) + 10;
    e = (s / 128 + 1) * 128;
    rise_a = -1; rise_b = -1; ws_a = -1; ws_b = -1; first_se = -1;
    fc128 = 16'hdead;
    drive_start(8'd0);
    prev_sck = 1'b0;
    prev_ws  = 1'b0;
    for (int n = 0; n <= e + 1; n++) begin
      if (n > 0) begin
        @(posedge sys_clk);
        #1;
      end
      stop = (n == s - 1);
      got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
      exp = model(n, p, W_EFF, s);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL div0_cycle n=%0d got=%h exp=%h", n, got, exp);
      end
      if (sck && !prev_sck) begin
        if (rise_a < 0) rise_a = n;
        else if (rise_b < 0) rise_b = n;
      end
      if (ws && !prev_ws) begin
        if (ws_a < 0) ws_a = n;
        else if (ws_b < 0) ws_b = n;
      end
      if (sample_en && (first_se < 0)) first_se = n;
      if (n == 128) fc128 = frame_cnt;
      prev_sck = sck;
      prev_ws  = ws;
    end
    stop = 1'b0;
    checks++;
    if (rise_b - rise_a != 2) begin
      errors++;
      $display("FAIL div0_sck_period got=%0d exp=2", rise_b - rise_a);
    end
    checks++;
    if (ws_b - ws_a != 128) begin
      errors++;
      $display("FAIL div0_ws_period got=%0d exp=128", ws_b - ws_a);
    end
    checks++;
    if (first_se != W_EFF * 128 + 1) begin
      errors++;
      $display("FAIL div0_first_sample got=%0d exp=%0d", first_se, W_EFF * 128 + 1);
    end
    checks++;
    if (fc128 !== ((W_EFF == 0) ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL div0_frame_cnt_64sck got=%0d exp=%0d", fc128, (W_EFF == 0) ? 1 : 0);
    end
    $display("txn div0: warmup=%0d first_sample=%0d sck_per=%0d ws_per=%0d",
             W_EFF, first_se, rise_b - rise_a, ws_b - ws_a);
  endtask

  task automatic test_stop_drain();
    int p, fl, s, e, fd_after;
    logic [20:0] got, exp;
    p  = 4;
    fl = 128 * p;
    s  = fl * (W_EFF + 2) + 64 + int'($urandom_range(0, 380));
    e  = fl * (W_EFF + 3);
    fd_after = 0;
    drive_start(8'd3);
    for (int n = 0; n <= e + 1; n++) begin
      if (n > 0) begin
        @(posedge sys_clk);
        #1;
      end
      stop = (n == s - 1);
      got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
      exp = model(n, p, W_EFF, s);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drain_cycle n=%0d got=%h exp=%h", n, got, exp);
      end
      if ((n > s) && frame_done) fd_after++;
    end
    stop = 1'b0;
    checks++;
    if (fd_after != 1) begin
      errors++;
      $display("FAIL drain_one_frame_done got=%0d exp=1", fd_after);
    end
    checks++;
    if ({busy, sck, ws, frame_cnt} !== {3'b000, 16'd3}) begin
      errors++;
      $display("FAIL drain_final got=%b%b%b/%0d exp=000/3", busy, sck, ws, frame_cnt);
    end
    $display("txn stop_drain: div=3 stop_edge=%0d idle_edge=%0d frame_cnt=%0d", s, e, frame_cnt);
  endtask

  task automatic test_start_stop_same();
    int busy_seen, sck_edges;
    logic prev_sck;
    busy_seen = 0;
    sck_edges = 0;
    div_half = 8'($urandom_range(0, 3));
    start = 1'b1;
    stop  = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    prev_sck = sck;
    for (int i = 0; i < 24; i++) begin
      if (busy) busy_seen++;
      if (sck != prev_sck) sck_edges++;
      prev_sck = sck;
      @(posedge sys_clk);
      #1;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL startstop_busy got=%0d exp=0", busy_seen);
    end
    checks++;
    if (sck_edges != 0) begin
      errors++;
      $display("FAIL startstop_sck_edges got=%0d exp=0", sck_edges);
    end
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL startstop_frame_cnt_hold got=%0d exp=3", frame_cnt);
    end
    $display("txn start_stop_same: busy_cycles=%0d sck_edges=%0d", busy_seen, sck_edges);
  endtask

  task automatic test_div_change();
    int p, fl, s, e, chg_n, rst_n2, rise_a, rise_b;
    logic [15:0] fc_restart;
    logic prev_sck;
    logic [20:0] got, exp;
    p  = 6;
    fl = 128 * p;
    chg_n  = fl * W_EFF + 30;
    rst_n2 = fl * (W_EFF + 1) + 50;
    s  = fl * (W_EFF + 2) + 20;
    e  = fl * (W_EFF + 3);
    rise_a = -1; rise_b = -1;
    fc_restart = 16'hdead;
    drive_start(8'd5);
    prev_sck = 1'b0;
    for (int n = 0; n <= e + 1; n++) begin
      if (n > 0) begin
        @(posedge sys_clk);
        #1;
      end
      stop  = (n == s - 1);
      start = (n == rst_n2);
      if (n == chg_n) div_half = 8'd1;
      got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
      exp = model(n, p, W_EFF, s);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL divchg_cycle n=%0d got=%h exp=%h", n, got, exp);
      end
      if ((n > chg_n) && sck && !prev_sck) begin
        if (rise_a < 0) rise_a = n;
        else if (rise_b < 0) rise_b = n;
      end
      if (n == rst_n2 + 2) fc_restart = frame_cnt;
      prev_sck = sck;
    end
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (rise_b - rise_a != 12) begin
      errors++;
      $display("FAIL divchg_sck_period got=%0d exp=12", rise_b - rise_a);
    end
    checks++;
    if (fc_restart !== 16'd1) begin
      errors++;
      $display("FAIL divchg_restart_keeps_cnt got=%0d exp=1", fc_restart);
    end
    $display("txn div_change: sck_per=%0d frame_cnt_after_restart=%0d", rise_b - rise_a, fc_restart);
  endtask

  task automatic test_random();
    int d, p, fl, s, e;
    logic [20:0] got, exp;
    for (int r = 0; r < 2; r++) begin
      d  = int'($urandom_range(0, 4));
      p  = d + 1;
      fl = 128 * p;
      s  = fl * (W_EFF + int'($urandom_range(0, 1))) + int'($urandom_range(1, 127 * p));
      e  = (s / fl + 1) * fl;
      drive_start(8'(d));
      for (int n = 0; n <= e + 1; n++) begin
        if (n > 0) begin
          @(posedge sys_clk);
          #1;
        end
        stop  = (n == s - 1);
        // Start noise while busy must be ignored.
        start = (n < e - 1) ? 1'($urandom) : 1'b0;
        div_half = 8'($urandom);
        got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
        exp = model(n, p, W_EFF, s);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random_cycle r=%0d n=%0d got=%h exp=%h", r, n, got, exp);
        end
      end
      start = 1'b0;
      stop  = 1'b0;
      $display("txn random: div=%0d stop_edge=%0d idle_edge=%0d frame_cnt=%0d", d, s, e, frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int d, p, fl, n_r;
    logic [20:0] got, exp;
    d  = int'($urandom_range(0, 3));
    p  = d + 1;
    fl = 128 * p;
    n_r = fl * W_EFF + 2 * p * 17 + int'($urandom_range(0, 2 * p - 1));
    drive_start(8'(d));
    for (int n = 0; n <= n_r; n++) begin
      if (n > 0) begin
        @(posedge sys_clk);
        #1;
      end
      got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
      exp = model(n, p, W_EFF, -1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rstmid_cycle n=%0d got=%h exp=%h", n, got, exp);
      end
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL rstmid_async_clear got=%h exp=%h", got, 21'd0);
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      div_half = 8'($urandom);
      @(posedge sys_clk);
      #1;
      got = {busy, sck, ws, sample_en, frame_done, frame_cnt};
      checks++;
      if (got !== 21'd0) begin
        errors++;
        $display("FAIL rstmid_quiet i=%0d got=%h exp=%h", i, got, 21'd0);
      end
    end
    $display("txn reset_midframe: div=%0d reset_edge=%0d bit=17", d, n_r);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_div0();
    test_stop_drain();
    test_start_stop_same();
    test_div_change();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
